// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron bank datapath.
// NEURON_BANK_ROUND_EN selects round-half-up before the output shift.
package neuron_pkg;

    typedef enum logic {
        ACCUM,
        HOLD
    } state_e;

    localparam int SAT_W = 128;

    function automatic int min_acc_width(input int in_w, input int n_in);
        return 2 * in_w + $clog2(n_in) + 1;
    endfunction

    // Optional ReLU, then signed clamp to an out_w-bit range.
    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] s,
        input int unsigned             out_w,
        input logic                    relu
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = signed'((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
        lo = ~hi;
        if (relu && (s < 0)) begin
            return '0;
        end else if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/neuron_lane.sv
// One MAC lane: accumulator plus final bias/shift/activation stage.
// NEURON_BANK_ROUND_EN adds a half-LSB before the output shift.
module neuron_lane
    import neuron_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SHIFT = 15,
    parameter int ACC_WIDTH = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        beat,
    input  logic                        last,
    input  logic signed [IN_WIDTH-1:0]  data_in,
    input  logic signed [IN_WIDTH-1:0]  weight_in,
    input  logic signed [IN_WIDTH-1:0]  bias_in,
    input  logic                        relu_en,
    output logic        [OUT_WIDTH-1:0] data_out
);

`ifdef NEURON_BANK_ROUND_EN
    localparam logic signed [ACC_WIDTH-1:0] RND =
        (ACC_WIDTH'(1) << OUT_SHIFT) >> 1;
`else
    localparam logic signed [ACC_WIDTH-1:0] RND = '0;
`endif

    logic signed [2*IN_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  bias_al;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic        [OUT_WIDTH-1:0]  res;

    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic        [OUT_WIDTH-1:0]  out_q, out_d;

    assign prod     = data_in * weight_in;
    assign prod_ext = ACC_WIDTH'(prod);
    // Q1.x bias lines up with the Q2.(2x) product scale.
    assign bias_al  = ACC_WIDTH'(bias_in) <<< (IN_WIDTH - 1);
    assign sum      = acc_q + prod_ext + bias_al + RND;
    assign shifted  = sum >>> OUT_SHIFT;
    assign res      = OUT_WIDTH'(sat_relu(SAT_W'(shifted),
                                          OUT_WIDTH, relu_en));

    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        if (last) begin
            acc_d = '0;
            out_d = res;
        end else if (beat) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign data_out = out_q;

endmodule

// File: rtl/neuron_bank.sv
// Parallel neuron bank: shared activation stream, per-lane weights.
// NEURON_BANK_ROUND_EN selects round-half-up output scaling.
module neuron_bank
    import neuron_pkg::*;
#(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int NUM_NEURONS = 4,
    parameter int NUM_INPUTS  = 784,
    parameter int OUT_SHIFT   = 15,
    parameter int ACC_WIDTH   = 48
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_WIDTH-1:0]              data_in,
    input  logic [NUM_NEURONS*IN_WIDTH-1:0]  weight_in,
    input  logic [NUM_NEURONS*IN_WIDTH-1:0]  bias_in,
    input  logic                             relu_en,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_NEURONS*OUT_WIDTH-1:0] data_out
);

    localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    if (ACC_WIDTH < min_acc_width(IN_WIDTH, NUM_INPUTS)) begin : g_acc_chk
        $error("neuron_bank: ACC_WIDTH too small");
    end
    if (ACC_WIDTH >= SAT_W) begin : g_sat_chk
        $error("neuron_bank: ACC_WIDTH exceeds saturation width");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic               beat;
    logic               last;

    assign in_ready = (state_q == ACCUM) && !rst;
    assign beat     = in_valid && in_ready;
    assign last     = beat && (count_q == CNT_W'(NUM_INPUTS - 1));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ACCUM: begin
                if (last) begin
                    state_d     = HOLD;
                    count_d     = '0;
                    out_valid_d = 1'b1;
                end else if (beat) begin
                    count_d = count_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_lane
        neuron_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .OUT_SHIFT (OUT_SHIFT),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .beat      (beat),
            .last      (last),
            .data_in   (data_in),
            .weight_in (weight_in[k*IN_WIDTH +: IN_WIDTH]),
            .bias_in   (bias_in[k*IN_WIDTH +: IN_WIDTH]),
            .relu_en   (relu_en),
            .data_out  (data_out[k*OUT_WIDTH +: OUT_WIDTH])
        );
    end

endmodule

// File: tb/tb_neuron_bank.sv
// Directed plus randomized bench for neuron_bank (4 inputs, 2 lanes).
// Build with NEURON_BANK_ROUND_EN to exercise the rounding variant.
module tb_neuron_bank;

    localparam int IW = 16;
    localparam int OW = 16;
    localparam int NN = 2;
    localparam int NI = 4;
    localparam int OS = 15;
    localparam int AW = 48;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IW-1:0]    data_in = '0;
    logic [NN*IW-1:0] weight_in = '0;
    logic [NN*IW-1:0] bias_in = '0;
    logic             relu_en = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [NN*OW-1:0] data_out;

    int n_chk = 0;
    int n_pass = 0;

    logic signed [IW-1:0] vd [NI];
    logic signed [IW-1:0] vw [NN][NI];
    logic signed [IW-1:0] vb [NN];
    logic                 vr;

    always #5 clk = ~clk;

    neuron_bank #(
        .IN_WIDTH    (IW),
        .OUT_WIDTH   (OW),
        .NUM_NEURONS (NN),
        .NUM_INPUTS  (NI),
        .OUT_SHIFT   (OS),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .weight_in (weight_in),
        .bias_in   (bias_in),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Dot product in wide integers, bias at product scale, floor/round
    // shift, then ReLU and clamp.
    function automatic logic [NN*OW-1:0] model();
        logic [NN*OW-1:0] r;
        longint s;
        r = '0;
        for (int k = 0; k < NN; k++) begin
            s = 0;
            for (int i = 0; i < NI; i++)
                s += longint'(vd[i]) * longint'(vw[k][i]);
            s += longint'(vb[k]) * 32768;
`ifdef NEURON_BANK_ROUND_EN
            s += 16384;
`endif
            s = s >>> OS;
            if (vr && s < 0) s = 0;
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            r[k*OW +: OW] = OW'(s);
        end
        return r;
    endfunction

    task automatic set_vec(input logic [15:0] d, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] b0,
                           input logic [15:0] b1, input logic r);
        for (int i = 0; i < NI; i++) begin
            vd[i] = d;
            vw[0][i] = w0;
            vw[1][i] = w1;
        end
        vb[0] = b0;
        vb[1] = b1;
        vr = r;
    endtask

    task automatic run_vec(input string tag, input logic [NN*OW-1:0] exp,
                           input int hold, input bit gaps);
        logic [NN*OW-1:0] held;
        for (int i = 0; i < NI; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    data_in = 16'($urandom);
                    @(negedge clk);
                end
            end
            chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
            if (i == NI - 1)
                chk({tag, "_pre_valid"}, 64'(out_valid), 64'd0);
            in_valid = 1'b1;
            data_in = vd[i];
            weight_in = {vw[1][i], vw[0][i]};
            if (i == NI - 1) begin
                bias_in = {vb[1], vb[0]};
                relu_en = vr;
            end else begin
                bias_in = 32'($urandom);
                relu_en = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(data_out), 64'(exp));
        held = data_out;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            data_in = 16'($urandom);
            weight_in = 32'($urandom);
            @(negedge clk);
            chk({tag, "_hold_data"}, 64'(data_out), 64'(held));
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        data_in = 16'($urandom);
        @(negedge clk);
        chk({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_drain_ready"}, 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        set_vec(16'h4000, 16'h2000, 16'h2000, 16'h0000, 16'h2000, 1'b0);
        run_vec("basic", 32'h6000_4000, 0, 1'b0);

        set_vec(16'h4000, 16'hE000, 16'hE000, 16'h0000, 16'h0000, 1'b1);
        run_vec("relu_on", 32'h0000_0000, 0, 1'b0);
        set_vec(16'h4000, 16'hE000, 16'hE000, 16'h0000, 16'h0000, 1'b0);
        run_vec("relu_off", 32'hC000_C000, 0, 1'b0);

        set_vec(16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 1'b0);
        run_vec("sat", 32'h8000_7FFF, 0, 1'b0);

        set_vec(16'h4000, 16'h2000, 16'h2000, 16'h0000, 16'h2000, 1'b0);
        run_vec("bp", 32'h6000_4000, 5, 1'b0);
        set_vec(16'h4000, 16'hE000, 16'hE000, 16'h0000, 16'h0000, 1'b0);
        run_vec("after_bp", 32'hC000_C000, 0, 1'b0);

        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            data_in = 16'h7FFF;
            weight_in = 32'h7FFF_7FFF;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(data_out), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_data", 64'(data_out), 64'd0);
        set_vec(16'h4000, 16'h2000, 16'h2000, 16'h0000, 16'h2000, 1'b0);
        run_vec("after_rst", 32'h6000_4000, 0, 1'b0);

        set_vec(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        vd[0] = 16'h0001;
        vw[0][0] = 16'h4000;
        vw[1][0] = 16'h4000;
`ifdef NEURON_BANK_ROUND_EN
        run_vec("round", 32'h0001_0001, 0, 1'b0);
`else
        run_vec("round", 32'h0000_0000, 0, 1'b0);
`endif

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NI; i++) begin
                vd[i] = 16'($urandom);
                for (int k = 0; k < NN; k++) begin
                    vw[k][i] = 16'($urandom);
                    if (t[0]) vw[k][i] = vw[k][i] >>> 3;
                end
            end
            for (int k = 0; k < NN; k++) vb[k] = 16'($urandom);
            vr = 1'($urandom_range(0, 1));
            run_vec($sformatf("rand%0d", t), model(),
                    int'($urandom_range(0, 3)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
